// File: rtl/port_link_arbiter_pkg.sv
// Shared types for the outbound router-link arbiter: packet layout, FSM states
// and the byte-select helper used by the serialiser.
package port_link_arbiter_pkg;

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dest;
    logic [23:0] data;
  } pkt_t;

  localparam int BEATS_PER_PKT = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_SEND
  } arb_state_t;

  // Byte order on the link: header {src,dest} first, then data MSB to LSB.
  function automatic logic [7:0] pkt_byte(input pkt_t pkt, input logic [1:0] beat);
    case (beat)
      2'd0:    return {pkt.src, pkt.dest};
      2'd1:    return pkt.data[23:16];
      2'd2:    return pkt.data[15:8];
      default: return pkt.data[7:0];
    endcase
  endfunction

endpackage

// File: rtl/port_link_arbiter_if.sv
// Bundle of requester handshakes and the outbound free/put byte link.
// master = arbiter side, slave = requesters plus downstream receiver.
interface port_link_arbiter_if
  import port_link_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_valid;
  pkt_t [NUM_REQ-1:0] req_pkt;
  logic [NUM_REQ-1:0] req_ack;
  logic               free_outbound;
  logic               put_outbound;
  logic [7:0]         payload_outbound;
  logic               busy;
  logic [IDX_W-1:0]   grant_idx;

  modport master (
    input  req_valid, req_pkt, free_outbound,
    output req_ack, put_outbound, payload_outbound, busy, grant_idx
  );

  modport slave (
    output req_valid, req_pkt, free_outbound,
    input  req_ack, put_outbound, payload_outbound, busy, grant_idx
  );

endinterface

// File: rtl/port_link_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping at NUM_REQ. The pointer itself is held by the caller.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any_req
);

  logic found;
  int   cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_req = |req;
    found   = 1'b0;
    cand    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/port_link_arbiter.sv
// Shares one outbound router link among NUM_REQ sources: round-robin grant,
// packet latch, and 4-beat byte serialiser with all outputs registered.
module port_link_arbiter
  import port_link_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input logic                 clock,
  input logic                 reset,
  port_link_arbiter_if.master link
);

  localparam int              IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [1:0]      LAST_BEAT = 2'(BEATS_PER_PKT - 1);

  arb_state_t         state_q, state_d;
  logic [1:0]         beat_q, beat_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               put_q, put_d;
  logic [7:0]         payload_q, payload_d;
  logic               busy_q, busy_d;
  pkt_t               pkt_q, pkt_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (link.req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    ack_d       = '0;
    put_d       = 1'b0;
    payload_d   = '0;
    busy_d      = 1'b0;
    pkt_d       = pkt_q;
    case (state_q)
      ARB_IDLE: begin
        // Grant edge: ack, header byte and busy all appear in the same next cycle.
        if (link.free_outbound && arb_any) begin
          pkt_d       = link.req_pkt[arb_idx];
          ack_d       = arb_gnt;
          grant_idx_d = arb_idx;
          ptr_d       = (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
          busy_d      = 1'b1;
          put_d       = 1'b1;
          payload_d   = pkt_byte(link.req_pkt[arb_idx], 2'd0);
          beat_d      = 2'd0;
          state_d     = ARB_SEND;
        end
      end
      ARB_SEND: begin
        // free_outbound is deliberately not looked at once a packet has started.
        if (beat_q == LAST_BEAT) begin
          beat_d  = 2'd0;
          state_d = ARB_IDLE;
        end else begin
          beat_d    = beat_q + 2'd1;
          put_d     = 1'b1;
          busy_d    = 1'b1;
          payload_d = pkt_byte(pkt_q, beat_q + 2'd1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      beat_q      <= 2'd0;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      ack_q       <= '0;
      put_q       <= 1'b0;
      payload_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      ack_q       <= ack_d;
      put_q       <= put_d;
      payload_q   <= payload_d;
      busy_q      <= busy_d;
    end
  end

  // Packet latch is pure data; an abandoned packet is never re-read after reset.
  always_ff @(posedge clock) begin
    pkt_q <= pkt_d;
  end

  assign link.req_ack          = ack_q;
  assign link.put_outbound     = put_q;
  assign link.payload_outbound = payload_q;
  assign link.busy             = busy_q;
  assign link.grant_idx        = grant_idx_q;

endmodule
